// File: rtl/adder_accumulator_pkg.sv
// Shared constants and encodings for the adder-accumulator datapath.
// Imported by the interface, ALU and top.
package adder_accumulator_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        OUT_A     = 2'b00,
        OUT_B     = 2'b01,
        OUT_ALU   = 2'b10,
        OUT_FLAGS = 2'b11
    } out_sel_e;

endpackage

// File: rtl/adder_accumulator_if.sv
// Control/data bundle between the pad wrapper and the datapath.
// master drives controls and din; slave drives the output bus and flags.
interface adder_accumulator_if
    import adder_accumulator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] din;
    logic             load_a;
    logic             load_b;
    logic             sub;
    logic             acc;
    logic             out_en;
    logic [1:0]       out_sel;
    logic [WIDTH-1:0] bus_out;
    logic [WIDTH-1:0] bus_oe;
    logic             cf;
    logic             zf;

    modport master (
        output din,
        output load_a,
        output load_b,
        output sub,
        output acc,
        output out_en,
        output out_sel,
        input  bus_out,
        input  bus_oe,
        input  cf,
        input  zf
    );

    modport slave (
        input  din,
        input  load_a,
        input  load_b,
        input  sub,
        input  acc,
        input  out_en,
        input  out_sel,
        output bus_out,
        output bus_oe,
        output cf,
        output zf
    );
endinterface

// File: rtl/adder_accumulator_alu.sv
// Combinational adder/subtractor: a + b, or a + ~b + 1 when sub is set.
// carry is the bit-out of the MSB; for subtraction it means "no borrow".
module adder_accumulator_alu
    import adder_accumulator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;

    assign b_op = sub ? ~b : b;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    end

    assign result = sum[WIDTH-1:0];
    assign carry  = sum[WIDTH];
    assign zero   = (sum[WIDTH-1:0] == '0);
endmodule

// File: rtl/adder_accumulator.sv
// 8-bit accumulator datapath: registers A and B, ALU write-back into A
// with registered carry/zero flags, and a gated output mux.
module adder_accumulator
    import adder_accumulator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    adder_accumulator_if.slave  bus
);
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cf_q;
    logic             zf_q;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_z;
    logic [WIDTH-1:0] mux_out;

    adder_accumulator_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .sub    (bus.sub),
        .result (alu_r),
        .carry  (alu_c),
        .zero   (alu_z)
    );

    // acc wins over load_a; B loads independently and the ALU sees old B
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            cf_q <= 1'b0;
            zf_q <= 1'b0;
        end else if (ena) begin
            if (bus.acc) begin
                a_q  <= alu_r;
                cf_q <= alu_c;
                zf_q <= alu_z;
            end else if (bus.load_a) begin
                a_q <= bus.din;
            end
            if (bus.load_b) begin
                b_q <= bus.din;
            end
        end
    end

    always_comb begin
        mux_out = '0;
        if (bus.out_en) begin
            unique case (bus.out_sel)
                OUT_A:     mux_out = a_q;
                OUT_B:     mux_out = b_q;
                OUT_ALU:   mux_out = alu_r;
                OUT_FLAGS: mux_out = {{(WIDTH-2){1'b0}}, cf_q, zf_q};
            endcase
        end
    end

    assign bus.bus_out = mux_out;
    assign bus.bus_oe  = {WIDTH{bus.out_en}};
    assign bus.cf      = cf_q;
    assign bus.zf      = zf_q;
endmodule

// File: tb/tb_adder_accumulator.sv
// Directed plus randomized checks of the accumulator datapath against
// an arithmetic reference model.
module tb_adder_accumulator;
    logic clk;
    logic clk_run;
    logic rst;
    logic ena;
    int   checks;
    int   failures;

    int unsigned ma;
    int unsigned mb;
    int unsigned mcf;
    int unsigned mzf;

    adder_accumulator_if #(.WIDTH(8)) ifc ();

    adder_accumulator #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #20 if (clk_run) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // returns {carry, result}; subtraction carry means a >= b
    function automatic int unsigned alu_m(input int unsigned a,
                                          input int unsigned b,
                                          input bit s);
        int unsigned res;
        int unsigned c;
        if (s) begin
            res = (a + 256 - b) % 256;
            c   = (a >= b) ? 1 : 0;
        end else begin
            res = (a + b) % 256;
            c   = (a + b > 255) ? 1 : 0;
        end
        return c * 256 + res;
    endfunction

    function automatic int unsigned exp_bus(input bit en, input int sel,
                                            input bit s);
        if (!en) return 0;
        case (sel)
            0: return ma;
            1: return mb;
            2: return alu_m(ma, mb, s) % 256;
            default: return mcf * 2 + mzf;
        endcase
    endfunction

    task automatic peek(input int sel, output logic [7:0] v);
        ifc.out_en  = 1'b1;
        ifc.out_sel = 2'(sel);
        #1;
        v = ifc.bus_out;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] v;
        for (int s = 0; s < 4; s++) begin
            peek(s, v);
            chk($sformatf("%s_sel%0d", tag, s), 32'(v),
                exp_bus(1'b1, s, ifc.sub));
        end
        chk({tag, "_oe"}, 32'(ifc.bus_oe), 32'hFF);
        chk({tag, "_cf"}, 32'(ifc.cf), mcf);
        chk({tag, "_zf"}, 32'(ifc.zf), mzf);
    endtask

    task automatic step(input bit e, input bit la, input bit lb,
                        input bit s, input bit ac, input logic [7:0] d);
        int unsigned r;
        @(negedge clk);
        ena        = e;
        ifc.load_a = la;
        ifc.load_b = lb;
        ifc.sub    = s;
        ifc.acc    = ac;
        ifc.din    = d;
        @(posedge clk);
        #1;
        if (e) begin
            r = alu_m(ma, mb, s);
            if (ac) begin
                ma  = r % 256;
                mcf = r / 256;
                mzf = (r % 256 == 0) ? 1 : 0;
            end else if (la) begin
                ma = d;
            end
            if (lb) mb = d;
        end
        check_all("step");
    endtask

    initial begin
        logic [7:0] v;
        checks     = 0;
        failures   = 0;
        clk_run    = 1'b0;
        rst        = 1'b0;
        ena        = 1'b0;
        ifc.din    = 8'h00;
        ifc.load_a = 1'b0;
        ifc.load_b = 1'b0;
        ifc.sub    = 1'b0;
        ifc.acc    = 1'b0;
        ifc.out_en = 1'b0;
        ifc.out_sel = 2'b00;
        ma = 0; mb = 0; mcf = 0; mzf = 0;

        #1 rst = 1'b1;
        #2;
        chk("rst_cf", 32'(ifc.cf), 0);
        chk("rst_zf", 32'(ifc.zf), 0);
        chk("rst_off_bus", 32'(ifc.bus_out), 0);
        chk("rst_off_oe", 32'(ifc.bus_oe), 0);
        peek(0, v);
        chk("rst_a", 32'(v), 8'h00);
        chk("rst_oe", 32'(ifc.bus_oe), 8'hFF);
        check_all("rst");
        rst     = 1'b0;
        clk_run = 1'b1;

        step(1, 1, 0, 0, 0, 8'h23);
        step(1, 0, 1, 0, 0, 8'h11);
        step(1, 0, 0, 0, 1, 8'h00);
        peek(0, v); chk("add_a", 32'(v), 8'h34);
        peek(2, v); chk("add_live", 32'(v), 8'h45);

        step(1, 1, 1, 0, 0, 8'hF0);
        step(1, 0, 1, 0, 0, 8'h20);
        step(1, 0, 0, 0, 1, 8'h00);
        peek(0, v); chk("ovf_a", 32'(v), 8'h10);
        chk("ovf_cf", 32'(ifc.cf), 1);
        step(1, 1, 1, 0, 0, 8'h80);
        step(1, 0, 0, 0, 1, 8'h00);
        peek(3, v); chk("ovf_flags", 32'(v), 8'h03);

        step(1, 1, 1, 1, 0, 8'h05);
        step(1, 0, 0, 1, 1, 8'h00);
        peek(3, v); chk("sub_eq_flags", 32'(v), 8'h03);
        step(1, 1, 0, 1, 0, 8'h03);
        step(1, 0, 0, 1, 1, 8'h00);
        peek(0, v); chk("sub_neg_a", 32'(v), 8'hFE);
        peek(3, v); chk("sub_neg_flags", 32'(v), 8'h00);

        step(1, 1, 1, 0, 0, 8'h01);
        step(1, 1, 0, 0, 1, 8'h77);
        peek(0, v); chk("prio_a", 32'(v), 8'h02);
        step(1, 0, 1, 0, 1, 8'h40);
        peek(0, v); chk("accb_a", 32'(v), 8'h03);
        peek(1, v); chk("accb_b", 32'(v), 8'h40);
        step(0, 1, 1, 1, 1, 8'hAA);

        step(1, 0, 1, 0, 0, 8'h5A);
        peek(1, v); chk("outb", 32'(v), 8'h5A);
        for (int s = 0; s < 4; s++) begin
            ifc.out_en  = 1'b0;
            ifc.out_sel = 2'(s);
            #1;
            chk("gate_bus", 32'(ifc.bus_out), 0);
            chk("gate_oe", 32'(ifc.bus_oe), 0);
        end

        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 2) == 0, 8'($urandom));
        end

        @(negedge clk);
        ena     = 1'b1;
        ifc.acc = 1'b1;
        #5 rst  = 1'b1;
        #2;
        ma = 0; mb = 0; mcf = 0; mzf = 0;
        chk("midrst_cf", 32'(ifc.cf), 0);
        chk("midrst_zf", 32'(ifc.zf), 0);
        check_all("midrst");
        ifc.acc    = 1'b0;
        ifc.load_a = 1'b0;
        ifc.load_b = 1'b0;
        rst        = 1'b0;
        step(1, 0, 0, 0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
